// File: rtl/dmem_bridge.sv
// dmem_bridge: converts single-cycle MEM-stage loads/stores into req/ack
// transactions on a slow data-RAM bus. While an access is in flight the
// pipeline is stalled. The bridge flags misaligned accesses and bus timeouts.
// Optional feature macro: DMEM_LASTREAD_EN adds a one-entry last-read buffer.
// With the buffer, a repeated aligned read of the same address completes in
// IDLE with zero stall.
module dmem_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  acc_err
);

    // TIMEOUT is limited to 1..255, so an 8-bit wait counter is enough
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nx;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] din_nx;
    logic                  req_nx;
    logic                  we_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic                  err_nx;

    logic                  access;
    logic                  aligned;
    logic                  timed_out;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;

    // Access qualification; a simultaneous ren/wen is handled as a write
    assign access    = mem_valid & (mem_ren | mem_wen);
    assign aligned   = (mem_addr[1:0] == 2'b00);
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef DMEM_LASTREAD_EN
    logic                  lr_valid;
    logic [ADDR_WIDTH-1:0] lr_tag;
    logic [DATA_WIDTH-1:0] lr_data;

    // A hit is a pure aligned read in IDLE that matches the buffered address
    assign hit      = lr_valid & (state == IDLE) & mem_valid & mem_ren & ~mem_wen
                      & aligned & (lr_tag == mem_addr);
    assign hit_data = lr_data;

    // Last-read buffer: fill on read completion, drop on write completion or error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_valid <= 1'b0;
            lr_tag   <= '0;
            lr_data  <= '0;
        end else if ((state == REQ) && bus_ack) begin
            if (!bus_we) begin
                lr_valid <= 1'b1;
                lr_tag   <= bus_addr;
                lr_data  <= bus_rdata;
            end else begin
                lr_valid <= 1'b0;
            end
        end else if (err_nx) begin
            lr_valid <= 1'b0;
        end
    end

    // A hit presents buffered data in the same cycle as the request
    assign mem_din = hit ? lr_data : din_q;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
    assign mem_din  = din_q;
`endif

    // Stall while an access is being launched or is on the bus; reset releases it
    assign mem_stall = ~rst & (((state == IDLE) & access & ~hit) | (state == REQ));

    // State and registered-output storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            din_q     <= '0;
            acc_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bus_req   <= req_nx;
            bus_we    <= we_nx;
            bus_addr  <= addr_nx;
            bus_wdata <= wdata_nx;
            din_q     <= din_nx;
            acc_err   <= err_nx;
        end
    end

    // Next-state logic; an ack wins over a coincident timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (access && !hit) begin
                    state_nx = aligned ? REQ : DONE;
                end
            end
            REQ: begin
                if (bus_ack || timed_out) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs, wait counter and load data
    always_comb begin
        req_nx   = bus_req;
        we_nx    = bus_we;
        addr_nx  = bus_addr;
        wdata_nx = bus_wdata;
        din_nx   = din_q;
        err_nx   = 1'b0;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (hit) begin
                    din_nx = hit_data;
                end else if (access) begin
                    if (aligned) begin
                        req_nx   = 1'b1;
                        we_nx    = mem_wen;
                        addr_nx  = mem_addr;
                        wdata_nx = mem_dout;
                    end else begin
                        din_nx = '0;
                        err_nx = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_nx = cnt + CNT_W'(1);
                if (bus_ack) begin
                    req_nx = 1'b0;
                    cnt_nx = '0;
                    if (!bus_we) begin
                        din_nx = bus_rdata;
                    end
                end else if (timed_out) begin
                    req_nx = 1'b0;
                    din_nx = '0;
                    err_nx = 1'b1;
                    cnt_nx = '0;
                end
            end
            DONE: begin
                cnt_nx = '0;
            end
            default: begin
                req_nx = 1'b0;
                cnt_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge, built with TIMEOUT=4.
// Also covers the DMEM_LASTREAD_EN buffer when that macro is defined.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        acc_err;

    int unsigned total  = 0;
    int unsigned passed = 0;

    dmem_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_stall(mem_stall),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .acc_err  (acc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
    endtask

    // One aligned access with the ack after 'waits' extra REQ cycles
    task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int waits, input logic [31:0] exp_din);
        tick();
        mem_valid = 1'b1;
        mem_ren   = ~wr;
        mem_wen   = wr;
        mem_addr  = addr;
        mem_dout  = wdata;
        #1;
        chk({tag, " idle stall"}, 32'(mem_stall), 32'd1);
        chk({tag, " idle req"}, 32'(bus_req), 32'd0);
        for (int i = 0; i <= waits; i++) begin
            tick();
            bus_ack   = (i == waits);
            bus_rdata = rdata;
            #1;
            chk({tag, " req"}, 32'(bus_req), 32'd1);
            chk({tag, " we"}, 32'(bus_we), 32'(wr));
            chk({tag, " addr"}, bus_addr, addr);
            chk({tag, " wdata"}, bus_wdata, wdata);
            chk({tag, " req stall"}, 32'(mem_stall), 32'd1);
        end
        tick();
        bus_ack = 1'b0;
        #1;
        chk({tag, " done stall"}, 32'(mem_stall), 32'd0);
        chk({tag, " done req"}, 32'(bus_req), 32'd0);
        chk({tag, " done din"}, mem_din, exp_din);
        chk({tag, " done err"}, 32'(acc_err), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk({tag, " after stall"}, 32'(mem_stall), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        idle_inputs();
        #3;
        chk("rst req", 32'(bus_req), 32'd0);
        chk("rst we", 32'(bus_we), 32'd0);
        chk("rst addr", bus_addr, 32'd0);
        chk("rst wdata", bus_wdata, 32'd0);
        chk("rst din", mem_din, 32'd0);
        chk("rst err", 32'(acc_err), 32'd0);
        chk("rst stall", 32'(mem_stall), 32'd0);
        tick();
        rst = 1'b0;

        // Read with immediate ack: two stall cycles
        do_access("rd1", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 32'h1234_5678);

        // Write, ack on the 4th REQ cycle coinciding with the timeout count
        do_access("wr1", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3, 32'h1234_5678);

        // Misaligned read: one stall, error pulse, din cleared
        tick();
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_addr  = 32'h0000_0013;
        #1;
        chk("mis stall", 32'(mem_stall), 32'd1);
        chk("mis req", 32'(bus_req), 32'd0);
        tick();
        #1;
        chk("mis done stall", 32'(mem_stall), 32'd0);
        chk("mis done req", 32'(bus_req), 32'd0);
        chk("mis done err", 32'(acc_err), 32'd1);
        chk("mis done din", mem_din, 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("mis after err", 32'(acc_err), 32'd0);
        chk("mis after req", 32'(bus_req), 32'd0);

        // Reload din so the timeout clear is observable
        do_access("rd2", 1'b0, 32'h0000_0008, 32'h0, 32'h5A5A_0001, 1, 32'h5A5A_0001);

        // No ack: four REQ cycles then abort
        tick();
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_addr  = 32'h0000_0030;
        #1;
        chk("to idle stall", 32'(mem_stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to req", 32'(bus_req), 32'd1);
            chk("to req stall", 32'(mem_stall), 32'd1);
        end
        tick();
        chk("to done req", 32'(bus_req), 32'd0);
        chk("to done err", 32'(acc_err), 32'd1);
        chk("to done din", mem_din, 32'd0);
        chk("to done stall", 32'(mem_stall), 32'd0);
        tick();
        idle_inputs();
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        #1;
        chk("late ack stall", 32'(mem_stall), 32'd0);
        chk("late ack err", 32'(acc_err), 32'd0);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("late ack din", mem_din, 32'd0);
        chk("late ack req", 32'(bus_req), 32'd0);
        chk("late ack err2", 32'(acc_err), 32'd0);

        // Reset during REQ drops req and stall immediately
        tick();
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_addr  = 32'h0000_0050;
        #1;
        tick();
        chk("rq req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rq rst req", 32'(bus_req), 32'd0);
        chk("rq rst stall", 32'(mem_stall), 32'd0);
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0077;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rq post req", 32'(bus_req), 32'd0);
        chk("rq post stall", 32'(mem_stall), 32'd0);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("rq post din", mem_din, 32'd0);
        chk("rq post err", 32'(acc_err), 32'd0);
        do_access("rd3", 1'b0, 32'h0000_0054, 32'h0, 32'h0BAD_C0DE, 0, 32'h0BAD_C0DE);

`ifdef DMEM_LASTREAD_EN
        // Buffer fill, zero-stall hit, invalidation by a write
        do_access("lr fill", 1'b0, 32'h0000_0040, 32'h0, 32'h0000_00AA, 0, 32'h0000_00AA);
        tick();
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_addr  = 32'h0000_0040;
        #1;
        chk("lr hit stall", 32'(mem_stall), 32'd0);
        chk("lr hit din", mem_din, 32'h0000_00AA);
        chk("lr hit req", 32'(bus_req), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("lr hit after req", 32'(bus_req), 32'd0);
        chk("lr hit after din", mem_din, 32'h0000_00AA);
        do_access("lr wr", 1'b1, 32'h0000_0044, 32'h0000_1111, 32'h0, 0, 32'h0000_00AA);
        do_access("lr miss", 1'b0, 32'h0000_0040, 32'h0, 32'h0000_00BB, 0, 32'h0000_00BB);
`else
        // Without the buffer a repeated read still goes to the bus
        do_access("rep1", 1'b0, 32'h0000_0040, 32'h0, 32'h0000_00AA, 0, 32'h0000_00AA);
        do_access("rep2", 1'b0, 32'h0000_0040, 32'h0, 32'h0000_00BB, 0, 32'h0000_00BB);
`endif

        // ren and wen together behave as a write
        tick();
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = 32'h0000_0060;
        mem_dout  = 32'h0000_600D;
        #1;
        chk("rw stall", 32'(mem_stall), 32'd1);
        tick();
        chk("rw we", 32'(bus_we), 32'd1);
        chk("rw wdata", bus_wdata, 32'h0000_600D);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("rw din", mem_din, 32'h0000_00BB);
        chk("rw err", 32'(acc_err), 32'd0);
        tick();
        idle_inputs();
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the pipeline MEM stage, between the datapath's data-memory port and a slow, handshaked data-RAM bus.
- Turns the single-cycle mem_ren/mem_wen/mem_addr/mem_dout access into a req/ack bus transaction.
- Returns read data on mem_din and raises mem_stall so the pipeline controller freezes IF..MEM until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr and bus_addr
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT, 255, maximum cycles in REQ without bus_ack before the access is aborted; legal range 1..255

Ports:
- clk  input  1  main clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_valid  input  1  MEM stage holds a valid instruction
- mem_ren  input  1  read request from MEM stage
- mem_wen  input  1  write request from MEM stage
- mem_addr  input  ADDR_WIDTH  byte address of access
- mem_dout  input  DATA_WIDTH  store data from datapath
- mem_din  output  DATA_WIDTH  load data to datapath
- mem_stall  output  1  freeze pipeline stages IF..MEM this cycle
- bus_req  output  1  bus transaction request
- bus_we  output  1  1 = write, 0 = read
- bus_addr  output  ADDR_WIDTH  word-aligned bus address
- bus_wdata  output  DATA_WIDTH  bus write data
- bus_ack  input  1  slave completion, single-cycle pulse
- bus_rdata  input  DATA_WIDTH  read data, valid when bus_ack=1
- acc_err  output  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (async, rst=1): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_din=0, acc_err=0, timeout counter=0.
  - Reset mid-transaction drops bus_req immediately; a late bus_ack is ignored.
- Access is defined as access = mem_valid & (mem_ren | mem_wen).
  - When mem_ren=1 and mem_wen=1 together, the access is treated as a write.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access & mem_addr[1:0]==0: latch bus_addr=mem_addr, bus_we=mem_wen, bus_wdata=mem_dout; set bus_req=1; go to REQ.
  - access & mem_addr[1:0]!=0: no bus request; mem_din<=0; acc_err<=1; go to DONE.
  - no access: stay in IDLE.
- REQ:
  - bus_req, bus_addr, bus_we and bus_wdata are held stable.
  - Counter increments each cycle.
  - bus_ack=1: for a read, mem_din<=bus_rdata; for a write, mem_din is unchanged. bus_req<=0; counter<=0; go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: bus_req<=0; mem_din<=0; acc_err<=1; counter<=0; go to DONE.
  - bus_ack takes priority over timeout when both occur in the same cycle.
- DONE:
  - mem_stall=0, so the pipeline advances at the end of this cycle.
  - acc_err drops back to 0 on leaving DONE.
  - Unconditionally go to IDLE; the next MEM instruction is evaluated there.
- mem_stall is combinational: (state==IDLE & access) | state==REQ.
- bus_ack outside REQ is ignored.
- Latency: with ack on the first REQ cycle, the result is in DONE 2 cycles after the access appears, so 2 stall cycles. Each extra wait cycle on the bus adds one stall cycle.
- mem_din holds its value until the next read completion or error.

Optional Feature:
- Macro: DMEM_LASTREAD_EN.
- When defined, the block keeps a one-entry read buffer: tag, data and valid bit.
  - Filled on every successful read completion.
  - Invalidated by any write completion, any error, and reset.
- In IDLE, an aligned read with valid & tag==mem_addr is a hit:
  - mem_stall=0 and mem_din=buffered data, combinationally in the same cycle.
  - No bus transaction is issued; state stays IDLE.
- When not defined: no buffer exists, and every access goes through REQ.

Test Plan:
- Aligned read 0x0000_0010, slave acks 1 cycle after req with bus_rdata=0x1234_5678 -> mem_stall high exactly 2 cycles; bus_req high 1 cycle; mem_din=0x1234_5678 in DONE; acc_err=0.
- Write 0x0000_0020, data 0xCAFE_F00D, ack delayed 3 cycles -> bus_we=1, bus_addr/bus_wdata stable for all 4 REQ cycles; stall 5 cycles; mem_din unchanged.
- Misaligned read 0x0000_0013 -> bus_req never asserted; 1 stall cycle; DONE with acc_err=1 for one cycle; mem_din=0.
- No ack, TIMEOUT=4 -> bus_req high 4 cycles then drops; acc_err pulse; mem_din=0; a late bus_ack in IDLE has no effect.
- rst asserted during REQ -> bus_req=0 and mem_stall=0 immediately; next access after release proceeds normally.
- With DMEM_LASTREAD_EN: read 0x40 (ack data 0xAA), then read 0x40 -> second read has zero stall and no bus_req; after a write to 0x44 (invalidates the buffer), a read of 0x40 issues a bus request again.
